// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the multi-cycle ALU.
package alu_pkg;

    localparam int ALU_CTRL_W = 3;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: result plus signed/unsigned compare flags.
// Latency: purely combinational.
// Backpressure: none, evaluated continuously.
module alu_comb
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res,
    output logic            lt,
    output logic            ltu
);

    always_comb begin
        lt  = $signed(a) < $signed(b);
        ltu = a < b;
        res = a;
        case (op)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_SLT: res = {{(XLEN-1){1'b0}}, lt};
            // shifts seed the iterative shifter with operand A
            ALU_SLL: res = a;
            ALU_SRL: res = a;
            default: res = a;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: one op per valid/ready handshake, shifts iterate one bit per cycle.
// Latency: 1 cycle for single-cycle ops, 1+shamt cycles for SLL/SRL.
// Backpressure: result and flags held in DONE until i_ready; no accept in the consume cycle.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ALU_CTRL_W-1:0] i_alucrtl,
    input  logic [XLEN-1:0]       i_srca,
    input  logic [XLEN-1:0]       i_srcb,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [XLEN-1:0]       o_result,
    output logic                  o_zero,
    output logic                  o_lt,
    output logic                  o_ltu
);

    alu_state_t         state;
    alu_op_t            op_q;
    logic [SHAMT_W-1:0] cnt;
    logic [XLEN-1:0]    result_q;
    logic               lt_q;
    logic               ltu_q;

    alu_op_t            op_in;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    comb_res;
    logic               comb_lt;
    logic               comb_ltu;
    logic               accept;

    assign op_in  = alu_op_t'(i_alucrtl);
    assign shamt  = i_srcb[SHAMT_W-1:0];
    assign accept = i_valid & o_ready;

    alu_comb #(
        .XLEN (XLEN)
    ) u_alu_comb (
        .op  (op_in),
        .a   (i_srca),
        .b   (i_srcb),
        .res (comb_res),
        .lt  (comb_lt),
        .ltu (comb_ltu)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            op_q     <= ALU_ADD;
            cnt      <= '0;
            result_q <= '0;
            lt_q     <= 1'b0;
            ltu_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= op_in;
                        lt_q     <= comb_lt;
                        ltu_q    <= comb_ltu;
                        result_q <= comb_res;
                        cnt      <= shamt;
                        // a zero shift amount is already complete with result = A
                        state    <= (is_shift(op_in) && (shamt != '0)) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    result_q <= (op_q == ALU_SLL) ? (result_q << 1) : (result_q >> 1);
                    cnt      <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready  = (state == IDLE);
    assign o_valid  = (state == DONE);
    assign o_result = result_q;
    assign o_zero   = (result_q == '0);
    assign o_lt     = lt_q;
    assign o_ltu    = ltu_q;

endmodule
